// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into short-press,
// long-press and double-click event pulses, plus a wrapping event counter.
// Optional feature macro: AUTO_REPEAT_EN -- when defined, holding the button
// after a long press re-emits LongPress every REP_CYC cycles.
module press_classifier #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DBL_MS    = 300,
    parameter int unsigned REPEAT_MS = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_level,
    output logic       o_short_press,
    output logic       o_long_press,
    output logic       o_double_click,
    output logic       o_pressed,
    output logic [7:0] o_event_count
);

    localparam logic [31:0] LONG_CYC = 32'(CLK_FREQ / 32'd1000 * LONG_MS);
    localparam logic [31:0] DBL_CYC  = 32'(CLK_FREQ / 32'd1000 * DBL_MS);
    localparam logic [31:0] REP_CYC  = 32'(CLK_FREQ / 32'd1000 * REPEAT_MS);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    // A window shorter than two cycles cannot be timed by the compare-to-N-1 scheme.
    if ((LONG_CYC < 32'd2) || (DBL_CYC < 32'd2) || (REP_CYC < 32'd2)) begin : g_bad_params
        $error("press_classifier: derived cycle counts must each be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_HELD   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic        r_prev;
    logic        r_pressed;
    logic        r_short;
    logic        r_long;
    logic        r_dbl;
    logic [7:0]  r_event_count;

    logic        w_rise;
    logic        w_fall;
    logic        w_short_nxt;
    logic        w_long_nxt;
    logic        w_dbl_nxt;
    logic        w_rep_clr;
    logic        w_cnt_clr;
    logic        w_any_pulse;

    assign w_rise      = i_level & ~r_prev;
    assign w_fall      = ~i_level & r_prev;
    assign w_any_pulse = w_short_nxt | w_long_nxt | w_dbl_nxt;

    // Next-state and pulse decode; a release or new press always beats a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        w_dbl_nxt   = 1'b0;
        w_rep_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESS1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PRESS1: begin
                if (w_fall) begin
                    w_state_nxt = ST_GAP;
                end else if (r_cnt == LONG_CYC - 32'd1) begin
                    w_state_nxt = ST_HELD;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if ((r_cnt == REP_CYC - 32'd1) && i_level) begin
                    w_long_nxt = 1'b1;
                    w_rep_clr  = 1'b1;
                end
`endif
                else begin
                    w_state_nxt = r_state;
                end
            end
            ST_GAP: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESS2;
                    w_dbl_nxt   = 1'b1;
                end else if (r_cnt == DBL_CYC - 32'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_short_nxt = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PRESS2: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_cnt_clr = (w_state_nxt != r_state) | w_rep_clr;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dwell-time counter: restarts on every state change, saturates instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 32'd0;
        end else if (w_cnt_clr) begin
            r_cnt <= 32'd0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Edge history; prev resets high so a button held through reset is ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev    <= 1'b1;
            r_pressed <= 1'b0;
        end else begin
            r_prev    <= i_level;
            r_pressed <= i_level;
        end
    end

    // Registered event pulses and the wrapping count of emitted events.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_short       <= 1'b0;
            r_long        <= 1'b0;
            r_dbl         <= 1'b0;
            r_event_count <= 8'd0;
        end else begin
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
            r_dbl   <= w_dbl_nxt;
            if (w_any_pulse) begin
                r_event_count <= r_event_count + 8'd1;
            end else begin
                r_event_count <= r_event_count;
            end
        end
    end

    assign o_short_press  = r_short;
    assign o_long_press   = r_long;
    assign o_double_click = r_dbl;
    assign o_pressed      = r_pressed;
    assign o_event_count  = r_event_count;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_CYC=10, DBL_CYC=4, REP_CYC=3.
module tb_press_classifier;

    logic       clk;
    logic       rst;
    logic       level;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic       pressed;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;

    // Pulse monitor state (edge numbers are the posedge on which the pulse was registered).
    int cyc     = 0;
    int n_short = 0;
    int n_long  = 0;
    int n_dbl   = 0;
    int n_multi = 0;
    int t_short = -1;
    int t_long  = -1;
    int t_long1 = -1;
    int t_dbl   = -1;

    press_classifier #(
        .CLK_FREQ (1000),
        .LONG_MS  (10),
        .DBL_MS   (4),
        .REPEAT_MS(3)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_level       (level),
        .o_short_press (short_press),
        .o_long_press  (long_press),
        .o_double_click(double_click),
        .o_pressed     (pressed),
        .o_event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally pulses shortly after each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (short_press) begin n_short++; t_short = cyc; end
        if (long_press) begin
            n_long++;
            if (t_long1 < 0) t_long1 = cyc;
            t_long = cyc;
        end
        if (double_click) begin n_dbl++; t_dbl = cyc; end
        if ((int'(short_press) + int'(long_press) + int'(double_click)) > 1) n_multi++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold(input logic v, input int n);
        level = v;
        tick(n);
    endtask

    task automatic clear_mon();
        n_short = 0; n_long = 0; n_dbl = 0; n_multi = 0;
        t_short = -1; t_long = -1; t_long1 = -1; t_dbl = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_mon();
    endtask

    task automatic test_reset();
        level = 1'b0;
        rst   = 1'b1;
        tick(2);
        checks++; if (short_press !== 1'b0) begin errors++; $display("FAIL reset_short got %b exp 0", short_press); end
        checks++; if (long_press !== 1'b0) begin errors++; $display("FAIL reset_long got %b exp 0", long_press); end
        checks++; if (double_click !== 1'b0) begin errors++; $display("FAIL reset_dbl got %b exp 0", double_click); end
        checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b exp 0", pressed); end
        checks++; if (event_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", event_count); end
        rst = 1'b0;
        tick(1);
        clear_mon();
    endtask

    task automatic test_short();
        int g;
        level = 1'b0;
        do_reset();
        hold(1'b1, 3);
        checks++; if (pressed !== 1'b1) begin errors++; $display("FAIL short_pressed got %b exp 1", pressed); end
        g = cyc + 1;
        hold(1'b0, 10);
        checks++; if (n_short != 1) begin errors++; $display("FAIL short_n got %0d exp 1", n_short); end
        checks++; if (t_short != g + 4) begin errors++; $display("FAIL short_time got %0d exp %0d", t_short, g + 4); end
        checks++; if ((n_long + n_dbl) != 0) begin errors++; $display("FAIL short_other got %0d exp 0", n_long + n_dbl); end
        checks++; if (event_count !== 8'd1) begin errors++; $display("FAIL short_count got %0d exp 1", event_count); end
        checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL short_released got %b exp 0", pressed); end
    endtask

    task automatic test_long(input int n_high);
        int e;
        int exp_n;
`ifdef AUTO_REPEAT_EN
        exp_n = (n_high >= 10) ? 1 + (n_high - 10 - 1) / 3 : 0;
`else
        exp_n = (n_high >= 10) ? 1 : 0;
`endif
        level = 1'b0;
        do_reset();
        e = cyc + 1;
        hold(1'b1, n_high);
        hold(1'b0, 10);
        checks++; if (n_long != exp_n) begin errors++; $display("FAIL long_n(%0d) got %0d exp %0d", n_high, n_long, exp_n); end
        checks++; if (t_long1 != e + 10) begin errors++; $display("FAIL long_time(%0d) got %0d exp %0d", n_high, t_long1, e + 10); end
        checks++; if ((n_short + n_dbl) != 0) begin errors++; $display("FAIL long_other(%0d) got %0d exp 0", n_high, n_short + n_dbl); end
        checks++; if (event_count !== 8'(exp_n)) begin errors++; $display("FAIL long_count(%0d) got %0d exp %0d", n_high, event_count, exp_n); end
`ifdef AUTO_REPEAT_EN
        if (n_high == 20) begin
            checks++; if (t_long != e + 19) begin errors++; $display("FAIL repeat_last got %0d exp %0d", t_long, e + 19); end
        end
`endif
    endtask

    task automatic test_double(input int gap_low, input string nm);
        int r2;
        level = 1'b0;
        do_reset();
        hold(1'b1, 2);
        hold(1'b0, gap_low);
        r2 = cyc + 1;
        hold(1'b1, 5);
        hold(1'b0, 10);
        checks++; if (n_dbl != 1) begin errors++; $display("FAIL %s_n got %0d exp 1", nm, n_dbl); end
        checks++; if (t_dbl != r2) begin errors++; $display("FAIL %s_time got %0d exp %0d", nm, t_dbl, r2); end
        checks++; if ((n_short + n_long) != 0) begin errors++; $display("FAIL %s_other got %0d exp 0", nm, n_short + n_long); end
        checks++; if (event_count !== 8'd1) begin errors++; $display("FAIL %s_count got %0d exp 1", nm, event_count); end
    endtask

    task automatic test_fall_at_timeout();
        int g;
        level = 1'b0;
        do_reset();
        hold(1'b1, 10);
        g = cyc + 1;
        hold(1'b0, 8);
        checks++; if (n_long != 0) begin errors++; $display("FAIL race_fall_long got %0d exp 0", n_long); end
        checks++; if (n_short != 1) begin errors++; $display("FAIL race_fall_short got %0d exp 1", n_short); end
        checks++; if (t_short != g + 4) begin errors++; $display("FAIL race_fall_time got %0d exp %0d", t_short, g + 4); end
    endtask

    task automatic test_reset_in_gap();
        level = 1'b0;
        do_reset();
        hold(1'b1, 1);
        hold(1'b0, 6);
        hold(1'b1, 2);
        hold(1'b0, 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        hold(1'b0, 10);
        checks++; if (n_short != 1) begin errors++; $display("FAIL gap_reset_n got %0d exp 1", n_short); end
        checks++; if (event_count !== 8'd0) begin errors++; $display("FAIL gap_reset_count got %0d exp 0", event_count); end
        checks++; if (short_press !== 1'b0) begin errors++; $display("FAIL gap_reset_out got %b exp 0", short_press); end
    endtask

    task automatic test_held_through_reset();
        level = 1'b1;
        do_reset();
        hold(1'b1, 15);
        checks++; if ((n_short + n_long + n_dbl) != 0) begin errors++; $display("FAIL held_reset_pulses got %0d exp 0", n_short + n_long + n_dbl); end
        checks++; if (pressed !== 1'b1) begin errors++; $display("FAIL held_reset_pressed got %b exp 1", pressed); end
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 8);
        checks++; if (n_short != 1) begin errors++; $display("FAIL held_reset_after got %0d exp 1", n_short); end
        checks++; if (event_count !== 8'd1) begin errors++; $display("FAIL held_reset_count got %0d exp 1", event_count); end
    endtask

    task automatic test_count_wrap();
        level = 1'b0;
        do_reset();
        for (int i = 0; i < 255; i++) begin
            hold(1'b1, 1);
            hold(1'b0, 6);
        end
        checks++; if (event_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", event_count); end
        hold(1'b1, 1);
        hold(1'b0, 6);
        checks++; if (event_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d exp 0", event_count); end
        checks++; if (n_short != 256) begin errors++; $display("FAIL wrap_n got %0d exp 256", n_short); end
    endtask

    initial begin
        rst   = 1'b0;
        level = 1'b0;
        test_reset();
        test_short();
        test_long(15);
        test_long(20);
        test_double(2, "dbl");
        test_double(4, "race_rise");
        test_fall_at_timeout();
        test_reset_in_gap();
        test_held_through_reset();
        test_count_wrap();
        checks++; if (n_multi != 0) begin errors++; $display("FAIL onehot got %0d exp 0", n_multi); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Sits directly downstream of the button debouncer. Consumes its clean, debounced level on the same clock.
- Classifies each gesture as a short press, long press or double click, and emits one-cycle event pulses to control logic (mode select, reset of counters, etc.).
- Also keeps a wrapping count of the events it has emitted.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- LONG_MS, 1000, hold time in ms that turns a press into a long press.
- DBL_MS, 300, maximum release gap in ms before a second press that still counts as a double click.
- REPEAT_MS, 250, auto-repeat period in ms; used only when AUTO_REPEAT_EN is defined.
- Derived cycle counts: LONG_CYC = CLK_FREQ/1000*LONG_MS, DBL_CYC = CLK_FREQ/1000*DBL_MS, REP_CYC = CLK_FREQ/1000*REPEAT_MS. All are computed at elaboration and must each be ≥2.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Level  input  1  debounced button level from the debouncer; 1 = pressed. Already synchronous to Clk.
- ShortPress  output  1  one-cycle pulse: single short press completed.
- LongPress  output  1  one-cycle pulse: hold reached LONG_CYC (repeats under AUTO_REPEAT_EN).
- DoubleClick  output  1  one-cycle pulse: second press began within DBL_CYC of the first release.
- Pressed  output  1  registered copy of Level.
- EventCount  output  8  count of emitted pulses (all three kinds), wrapping.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counter 0.
  - Edge register prev = 1, so a Level already high when reset releases is ignored until Level has gone low and high again.
- Edge detection:
  - rise = Level & ~prev; fall = ~Level & prev.
  - prev <= Level every cycle.
- Counter:
  - 32-bit cycle counter, cleared on every state change, incremented every cycle otherwise.
  - The counter saturates: it never wraps.
- States:
  - IDLE: on rise -> PRESS1.
  - PRESS1:
    - on fall -> GAP.
    - else if cnt == LONG_CYC-1 -> HELD, pulse LongPress.
    - If fall and timeout occur in the same cycle, fall wins (gesture stays short).
  - HELD: on fall -> IDLE. No pulse on release.
  - GAP:
    - on rise -> PRESS2, pulse DoubleClick.
    - else if cnt == DBL_CYC-1 -> IDLE, pulse ShortPress.
    - If rise and timeout occur in the same cycle, rise wins (double click).
  - PRESS2: on fall -> IDLE. A long hold here produces no LongPress.
- Pulse timing:
  - Pulses are registered and set on the same edge as the state transition. Each is high for exactly one cycle; at most one is high in any cycle.
  - LongPress is asserted LONG_CYC cycles after the PRESS1 entry edge.
  - ShortPress is asserted DBL_CYC cycles after the GAP entry edge. ShortPress latency is therefore inherently the release time plus the double-click window.
  - DoubleClick is asserted on the clock edge after the cycle in which rise was seen in GAP.
- EventCount: increments by 1 on the same edge as any pulse; 255 -> 0.
- Pressed: equals Level delayed one cycle (same value as prev).
- Reset mid-gesture: immediate return to IDLE; no pulse is emitted for the aborted gesture; EventCount is cleared.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In HELD, the counter restarts at entry.
  - Each time cnt == REP_CYC-1 with Level still high, LongPress pulses again, EventCount increments, and the counter clears.
  - If fall occurs in the same cycle, fall wins: no pulse, go to IDLE.
- Not defined: HELD emits nothing. REPEAT_MS is unused and no repeat logic is synthesized.

Test Plan:
All scenarios use CLK_FREQ=1000, LONG_MS=10, DBL_MS=4, REPEAT_MS=3, giving LONG_CYC=10, DBL_CYC=4, REP_CYC=3.
- Short press: Level high 3 cycles, then low -> exactly one ShortPress 4 cycles after the GAP entry; EventCount=1; no other pulses.
- Long press: Level high 15 cycles -> one LongPress 10 cycles after the PRESS1 entry edge; the release emits nothing; EventCount=1.
- Double click: high 2, low 2, high 5, low -> DoubleClick one cycle after the second rise is seen; no ShortPress; EventCount=1.
- Boundary races:
  - Fall exactly on PRESS1 count 9 -> ShortPress path, no LongPress.
  - Rise exactly on GAP count 3 -> DoubleClick, no ShortPress.
- Reset:
  - Reset asserted in GAP -> no ShortPress; outputs 0.
  - Level held high across reset release -> no events until a low-high cycle.
- AUTO_REPEAT_EN: hold 20 cycles -> LongPress at cycle 10, then every 3 cycles (13, 16, 19), 4 pulses total. Also check EventCount wraps 255 -> 0 after 256 short presses.
